serial_substractor: RTL and testbench

Bit-serial multi-bit subtractor that computes `a - b - bin` LSB-first, one bit per clock, with a single full-subtractor cell and a registered borrow. It is the sequential datapath stage wrapped around the team's one-bit full subtractor. Operands are loaded in parallel on a start request and shifted through the cell. The difference and final borrow are returned in parallel with a one-cycle done pulse.

---
 rtl/serial_substractor.sv | 120 ++++++++++++
 tb/tb_serial_substractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_substractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first through one full-subtractor cell
// with a registered borrow, returning the difference and final borrow in parallel.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; operands captured on the accept edge
// S_RUN  | one bit per cycle shifted through the cell, WIDTH cycles
// S_DONE | diff/bout valid, done pulses for this single cycle
module serial_substractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  sd_q, sd_d;
    logic              br_q, br_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;

    logic              cell_d;
    logic              cell_nb;

    // One-bit full subtractor on the current LSBs and the stored borrow.
    always_comb begin
        cell_d  = sa_q[0] ^ sb_q[0] ^ br_q;
        cell_nb = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & br_q) | (sb_q[0] & br_q);
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                // Shift-and-insert form stays legal when WIDTH is 1.
                sd_d  = (sd_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                br_d  = cell_nb;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    diff_d  = sd_d;
                    bout_d  = cell_nb;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_substractor.sv
// Bench for serial_substractor: WIDTH=8 and WIDTH=1 instances share stimulus and are
// compared every cycle against an arithmetic model of the operation timeline.
module tb_serial_substractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       busy8, done8, bout8;
    logic [7:0] diff8;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_en = 1'b0;

    // Model: phase 0 = idle, 1..W = run steps pending, W+1 = done cycle.
    int          m_phase [2] = '{0, 0};
    logic [63:0] m_res   [2] = '{64'd0, 64'd0};
    logic [63:0] m_diff  [2] = '{64'd0, 64'd0};
    logic        m_bout  [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    serial_substractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_substractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a[0:0]), .b(b[0:0]), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            int          w;
            logic [63:0] mask;
            w    = (l == 0) ? 8 : 1;
            mask = (64'd1 << w) - 64'd1;
            if (rst) begin
                m_phase[l] = 0;
                m_diff[l]  = '0;
                m_bout[l]  = 1'b0;
            end else if (m_phase[l] == 0) begin
                if (start) begin
                    m_res[l]   = ({56'd0, a} & mask) - ({56'd0, b} & mask) - {63'd0, bin};
                    m_phase[l] = 1;
                end
            end else if (m_phase[l] == w) begin
                m_diff[l]  = m_res[l] & mask;
                m_bout[l]  = m_res[l][w];
                m_phase[l] = w + 1;
            end else if (m_phase[l] == w + 1) begin
                m_phase[l] = 0;
            end else begin
                m_phase[l] = m_phase[l] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("w8 busy", {63'd0, busy8}, {63'd0, m_phase[0] != 0});
            check("w8 done", {63'd0, done8}, {63'd0, m_phase[0] == 9});
            check("w8 diff", {56'd0, diff8}, m_diff[0]);
            check("w8 bout", {63'd0, bout8}, {63'd0, m_bout[0]});
            check("w1 busy", {63'd0, busy1}, {63'd0, m_phase[1] != 0});
            check("w1 done", {63'd0, done1}, {63'd0, m_phase[1] == 2});
            check("w1 diff", {63'd0, diff1}, m_diff[1]);
            check("w1 bout", {63'd0, bout1}, {63'd0, m_bout[1]});
        end
    end

    task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge right after the accept edge; n = cycles until done seen.
    task automatic wait_done8(output int n);
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) check("done8 timeout", {63'd0, done8}, 64'd1);
    endtask

    initial begin
        int n;
        int dcnt;

        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset busy", {63'd0, busy8}, 64'd0);
        check("reset done", {63'd0, done8}, 64'd0);
        check("reset diff", {56'd0, diff8}, 64'd0);
        check("reset bout", {63'd0, bout8}, 64'd0);

        op(8'h35, 8'h12, 1'b0);
        wait_done8(n);
        check("t1 latency", n, 9);
        check("t1 diff", {56'd0, diff8}, 64'h23);
        check("t1 bout", {63'd0, bout8}, 64'd0);
        check("t1 model diff", m_diff[0], 64'h23);
        @(negedge clk);

        op(8'h00, 8'h01, 1'b0);
        wait_done8(n);
        check("t2a diff", {56'd0, diff8}, 64'hFF);
        check("t2a bout", {63'd0, bout8}, 64'd1);
        check("t2a model bout", {63'd0, m_bout[0]}, 64'd1);
        @(negedge clk);
        op(8'h80, 8'h80, 1'b1);
        wait_done8(n);
        check("t2b diff", {56'd0, diff8}, 64'hFF);
        check("t2b bout", {63'd0, bout8}, 64'd1);
        @(negedge clk);

        op(8'h35, 8'h12, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(n);
        check("t3 latency", n, 6);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3 diff", {56'd0, diff8}, 64'h23);
        check("t3 bout", {63'd0, bout8}, 64'd0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        check("t3 extra done", dcnt, 0);
        check("t3 diff held", {56'd0, diff8}, 64'h23);

        op(8'h35, 8'h12, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4 busy", {63'd0, busy8}, 64'd0);
        check("t4 diff", {56'd0, diff8}, 64'd0);
        check("t4 bout", {63'd0, bout8}, 64'd0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        check("t4 aborted done", dcnt, 0);
        op(8'hFF, 8'h0F, 1'b0);
        wait_done8(n);
        check("t4 diff after", {56'd0, diff8}, 64'hF0);
        check("t4 bout after", {63'd0, bout8}, 64'd0);
        @(negedge clk);

        start = 1'b1;
        dcnt  = 0;
        for (int i = 0; i < 60; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            bin = 1'($urandom);
            @(negedge clk);
            if (done8) dcnt++;
        end
        start = 1'b0;
        check("t5 done count", dcnt, 6);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            op(8'($urandom), 8'($urandom), 1'($urandom));
            wait_done8(n);
            check("rnd latency", n, 9);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
